// File: rtl/ram_pkg.sv
// Shared types and helpers for the single-port RAM with built-in clear sequencer.
package ram_pkg;

    typedef enum logic {
        CLR_CLEAR,
        CLR_READY
    } clr_state_e;

    typedef enum logic {
        WR_READ_FIRST,
        WR_WRITE_FIRST
    } wr_mode_e;

    // Widest word the lane-mask helper can expand; wider arrays are rejected at elaboration.
    localparam int unsigned MASK_MAX_W = 256;
    localparam int unsigned MASK_IDX_W = $clog2(MASK_MAX_W);

    // Expand lane write enables into a per-bit mask; the caller truncates to its word width.
    function automatic logic [MASK_MAX_W-1:0] lane_mask(
        input logic [MASK_MAX_W-1:0] wbe,
        input int unsigned           lane_width
    );
        logic [MASK_MAX_W-1:0] mask;
        int unsigned           lw;
        mask = '0;
        lw   = (lane_width == 0) ? 1 : lane_width;
        for (int unsigned b = 0; b < MASK_MAX_W; b++) begin
            mask[MASK_IDX_W'(b)] = wbe[MASK_IDX_W'(b / lw)];
        end
        return mask;
    endfunction

endpackage

// File: rtl/spram_core.sv
// Behavioural single-port array: bit-masked write, one-cycle registered read.
// Interchangeable with a foundry macro of the same port behaviour.
module spram_core
    import ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 22,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned WRITE_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic                  rd_i,
    input  logic [DATA_WIDTH-1:0] mask_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam wr_mode_e MODE = (WRITE_MODE != 0) ? WR_WRITE_FIRST : WR_READ_FIRST;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [DATA_WIDTH-1:0] old_word_c;
    logic [DATA_WIDTH-1:0] merged_c;

    assign old_word_c = mem_q[addr_i];
    assign merged_c   = (old_word_c & ~mask_i) | (wdata_i & mask_i);

    // Array storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= merged_c;
        end
    end

    // Read register only moves on user accesses, so it holds between them.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (en_i && rd_i) begin
            if ((MODE == WR_WRITE_FIRST) && we_i) begin
                rdata_q <= merged_c;
            end else begin
                rdata_q <= old_word_c;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spram_clr.sv
// Parametrised single-port RAM with lane enables, selectable read latency and
// a clear sequencer that sweeps every word to CLEAR_VALUE after reset or on request.
module spram_clr
    import ram_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH     = 22,
    parameter int unsigned           DEPTH          = 256,
    parameter int unsigned           ADDR_WIDTH     = $clog2(DEPTH),
    parameter int unsigned           LANE_WIDTH     = DATA_WIDTH,
    parameter int unsigned           LANES          = (DATA_WIDTH + LANE_WIDTH - 1) / LANE_WIDTH,
    parameter int unsigned           READ_LATENCY   = 1,
    parameter int unsigned           WRITE_MODE     = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [LANES-1:0]      wbe,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    input  logic                  clear_req,
    output logic                  ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
    localparam clr_state_e            RESET_STATE = CLEAR_ON_RESET ? CLR_CLEAR : CLR_READY;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spram_clr: DEPTH must be a power of two and at least 2");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $error("spram_clr: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH > MASK_MAX_W) begin : g_bad_width
        $error("spram_clr: DATA_WIDTH exceeds lane mask helper width");
    end

    clr_state_e            state_q;
    clr_state_e            state_d;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic [ADDR_WIDTH-1:0] cnt_d;
    logic                  ready_q;
    logic                  acc_vld_q;

    logic                  acc_c;
    logic [DATA_WIDTH-1:0] user_mask_c;
    logic                  core_en_c;
    logic                  core_we_c;
    logic                  core_rd_c;
    logic [DATA_WIDTH-1:0] core_mask_c;
    logic [ADDR_WIDTH-1:0] core_addr_c;
    logic [DATA_WIDTH-1:0] core_wdata_c;
    logic [DATA_WIDTH-1:0] core_rdata;

    // A clear_req in the same cycle does not block the access: ready is still high.
    assign acc_c       = ready_q & en;
    assign user_mask_c = DATA_WIDTH'(lane_mask(MASK_MAX_W'(wbe), LANE_WIDTH));

    // State register; ready tracks the state being entered so it moves with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RESET_STATE;
            cnt_q     <= '0;
            ready_q   <= (RESET_STATE == CLR_READY);
            acc_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= (state_d == CLR_READY);
            acc_vld_q <= acc_c;
        end
    end

    // Next state: one word per cycle in CLEAR; clear_req only heard in READY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLR_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = CLR_READY;
                end
            end
            CLR_READY: begin
                if (clear_req) begin
                    state_d = CLR_CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // Array port mux: sweep owns the array in CLEAR, user port in READY.
    always_comb begin
        core_en_c    = 1'b0;
        core_we_c    = 1'b0;
        core_rd_c    = 1'b0;
        core_mask_c  = '0;
        core_addr_c  = addr;
        core_wdata_c = wdata;
        unique case (state_q)
            CLR_CLEAR: begin
                core_en_c    = 1'b1;
                core_we_c    = 1'b1;
                core_mask_c  = '1;
                core_addr_c  = cnt_q;
                core_wdata_c = CLEAR_VALUE;
            end
            CLR_READY: begin
                core_en_c   = acc_c;
                core_we_c   = we;
                core_rd_c   = 1'b1;
                core_mask_c = user_mask_c;
            end
        endcase
    end

    spram_core #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .WRITE_MODE(WRITE_MODE)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .en_i   (core_en_c),
        .we_i   (core_we_c),
        .rd_i   (core_rd_c),
        .mask_i (core_mask_c),
        .addr_i (core_addr_c),
        .wdata_i(core_wdata_c),
        .rdata_o(core_rdata)
    );

    // Optional output stage; it drains independently of the clear FSM.
    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] rdata_q;
        logic                  rvalid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q  <= '0;
                rvalid_q <= 1'b0;
            end else begin
                rvalid_q <= acc_vld_q;
                if (acc_vld_q) begin
                    rdata_q <= core_rdata;
                end
            end
        end

        assign rdata  = rdata_q;
        assign rvalid = rvalid_q;
    end else begin : g_lat1
        assign rdata  = core_rdata;
        assign rvalid = acc_vld_q;
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_spram_clr.sv
// Directed bench: u0 is read-first, 8-bit lanes, latency 1; u1 is write-first,
// single lane, latency 2. Both share address/data/control stimulus.
module tb_spram_clr;

    logic        clk;
    logic        rst;
    logic        en;
    logic        we;
    logic [2:0]  wbe0;
    logic [0:0]  wbe1;
    logic [7:0]  addr;
    logic [21:0] wdata;
    logic        clear_req;
    logic [21:0] rdata0;
    logic [21:0] rdata1;
    logic        rvalid0;
    logic        rvalid1;
    logic        ready0;
    logic        ready1;

    int n_cmp = 0;
    int n_bad = 0;
    int low;
    int spur;

    spram_clr #(
        .LANE_WIDTH(8)
    ) u0 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .we       (we),
        .wbe      (wbe0),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata0),
        .rvalid   (rvalid0),
        .clear_req(clear_req),
        .ready    (ready0)
    );

    spram_clr #(
        .READ_LATENCY(2),
        .WRITE_MODE  (1)
    ) u1 (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .we       (we),
        .wbe      (wbe1),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata1),
        .rvalid   (rvalid1),
        .clear_req(clear_req),
        .ready    (ready1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One access followed by an idle cycle; e0/e1 are the data each instance returns.
    task automatic access(input string tag, input logic w, input logic [7:0] a,
                          input logic [21:0] d, input logic [2:0] b0, input logic b1,
                          input logic [21:0] e0, input logic [21:0] e1);
        en = 1'b1; we = w; addr = a; wdata = d; wbe0 = b0; wbe1 = b1;
        tick();
        en = 1'b0; we = 1'b0;
        chk({tag, ".rv0"}, 32'(rvalid0), 32'd1);
        chk({tag, ".rd0"}, 32'(rdata0), 32'(e0));
        chk({tag, ".rv1_early"}, 32'(rvalid1), 32'd0);
        tick();
        chk({tag, ".rv0_off"}, 32'(rvalid0), 32'd0);
        chk({tag, ".rd0_hold"}, 32'(rdata0), 32'(e0));
        chk({tag, ".rv1"}, 32'(rvalid1), 32'd1);
        chk({tag, ".rd1"}, 32'(rdata1), 32'(e1));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; wbe0 = '0; wbe1 = '0;
        addr = '0; wdata = '0; clear_req = 1'b0;

        // Reset into the sweep.
        tick();
        rst = 1'b0;
        chk("rst.ready0", 32'(ready0), 32'd0);
        chk("rst.ready1", 32'(ready1), 32'd0);
        chk("rst.rv0", 32'(rvalid0), 32'd0);
        chk("rst.rv1", 32'(rvalid1), 32'd0);
        chk("rst.rd0", 32'(rdata0), 32'd0);
        chk("rst.rd1", 32'(rdata1), 32'd0);
        low = 1;
        while (!ready0 && low < 400) begin
            tick();
            if (!ready0) low++;
        end
        chk("init.low_cycles", 32'(low), 32'd256);
        chk("init.ready1", 32'(ready1), 32'd1);

        // Freshly cleared words read back as zero.
        access("rd0",   1'b0, 8'd0,   22'h0, 3'b000, 1'b0, 22'h0, 22'h0);
        access("rd127", 1'b0, 8'd127, 22'h0, 3'b000, 1'b0, 22'h0, 22'h0);
        access("rd255", 1'b0, 8'd255, 22'h0, 3'b000, 1'b0, 22'h0, 22'h0);

        // Full write then read back.
        access("wr5", 1'b1, 8'd5, 22'h3ABCDE, 3'b111, 1'b1, 22'h0, 22'h3ABCDE);
        access("rd5", 1'b0, 8'd5, 22'h0, 3'b000, 1'b0, 22'h3ABCDE, 22'h3ABCDE);

        // Back-to-back: write 6, read 6, read 5.
        en = 1'b1; we = 1'b1; addr = 8'd6; wdata = 22'h155555; wbe0 = 3'b111; wbe1 = 1'b1;
        tick();
        we = 1'b0;
        chk("b2b.t1.rv0", 32'(rvalid0), 32'd1);
        chk("b2b.t1.rd0", 32'(rdata0), 32'h0);
        tick();
        addr = 8'd5;
        chk("b2b.t2.rd0", 32'(rdata0), 32'h155555);
        chk("b2b.t2.rv1", 32'(rvalid1), 32'd1);
        chk("b2b.t2.rd1", 32'(rdata1), 32'h155555);
        tick();
        en = 1'b0;
        chk("b2b.t3.rd0", 32'(rdata0), 32'h3ABCDE);
        chk("b2b.t3.rd1", 32'(rdata1), 32'h155555);
        tick();
        chk("b2b.t4.rv0", 32'(rvalid0), 32'd0);
        chk("b2b.t4.rv1", 32'(rvalid1), 32'd1);
        chk("b2b.t4.rd1", 32'(rdata1), 32'h3ABCDE);
        tick();
        chk("b2b.t5.rv1", 32'(rvalid1), 32'd0);

        // Lane enables (u0 has three lanes, the top one 6 bits wide).
        access("lane.full", 1'b1, 8'd7, 22'h3FFFFF, 3'b111, 1'b1, 22'h0, 22'h3FFFFF);
        access("lane.mid",  1'b1, 8'd7, 22'h000000, 3'b010, 1'b0, 22'h3FFFFF, 22'h3FFFFF);
        access("lane.rd1",  1'b0, 8'd7, 22'h0, 3'b000, 1'b0, 22'h3F00FF, 22'h3FFFFF);
        access("lane.top",  1'b1, 8'd7, 22'h2AAAAA, 3'b100, 1'b1, 22'h3F00FF, 22'h2AAAAA);
        access("lane.rd2",  1'b0, 8'd7, 22'h0, 3'b000, 1'b0, 22'h2A00FF, 22'h2AAAAA);

        // Read-first vs write-first on the same write.
        access("wm.a", 1'b1, 8'd9, 22'h000011, 3'b111, 1'b1, 22'h0, 22'h000011);
        access("wm.b", 1'b1, 8'd9, 22'h000022, 3'b111, 1'b1, 22'h000011, 22'h000022);

        // Clear request with a concurrent write: the write is still taken.
        en = 1'b1; we = 1'b1; addr = 8'd3; wdata = 22'h012345; wbe0 = 3'b111; wbe1 = 1'b1;
        clear_req = 1'b1;
        tick();
        en = 1'b0; we = 1'b0; clear_req = 1'b0;
        chk("clr.ready0", 32'(ready0), 32'd0);
        chk("clr.ready1", 32'(ready1), 32'd0);
        chk("clr.rv0", 32'(rvalid0), 32'd1);
        chk("clr.rd0", 32'(rdata0), 32'h0);
        tick();
        chk("clr.rv1", 32'(rvalid1), 32'd1);
        chk("clr.rd1", 32'(rdata1), 32'h012345);
        chk("clr.rv0_off", 32'(rvalid0), 32'd0);
        low = 2;
        spur = 0;
        while (!ready0 && low < 400) begin
            en = ((low >= 10) && (low < 20)) || (low >= 240);
            we = (low < 20);
            addr = 8'd3; wdata = 22'h3FFFFF; wbe0 = 3'b111; wbe1 = 1'b1;
            clear_req = (low == 100);
            tick();
            if (rvalid0 || rvalid1) spur++;
            if (!ready0) low++;
        end
        en = 1'b0; we = 1'b0; clear_req = 1'b0;
        chk("clr.low_cycles", 32'(low), 32'd256);
        chk("clr.spurious_rvalid", 32'(spur), 32'd0);
        chk("clr.ready1_back", 32'(ready1), 32'd1);
        access("clr.rd3", 1'b0, 8'd3, 22'h0, 3'b000, 1'b0, 22'h0, 22'h0);

        // Reset in the middle of a sweep restarts it.
        access("mid.wr5", 1'b1, 8'd5, 22'h0ABCDE, 3'b111, 1'b1, 22'h0, 22'h0ABCDE);
        access("mid.rd5", 1'b0, 8'd5, 22'h0, 3'b000, 1'b0, 22'h0ABCDE, 22'h0ABCDE);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("mid.ready_drop", 32'(ready0), 32'd0);
        repeat (100) tick();
        chk("mid.ready_low", 32'(ready0), 32'd0);
        chk("mid.rd0_hold", 32'(rdata0), 32'h0ABCDE);
        chk("mid.rd1_hold", 32'(rdata1), 32'h0ABCDE);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid.rst.rd0", 32'(rdata0), 32'h0);
        chk("mid.rst.rd1", 32'(rdata1), 32'h0);
        chk("mid.rst.rv0", 32'(rvalid0), 32'd0);
        chk("mid.rst.rv1", 32'(rvalid1), 32'd0);
        chk("mid.rst.ready0", 32'(ready0), 32'd0);
        low = 1;
        while (!ready0 && low < 400) begin
            tick();
            if (!ready0) low++;
        end
        chk("mid.low_cycles", 32'(low), 32'd256);
        access("mid.rd5_cleared", 1'b0, 8'd5, 22'h0, 3'b000, 1'b0, 22'h0, 22'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spram_clr.md
Name: spram_clr

Overview:
- Parametrised single-port synchronous RAM for cache tag/data arrays.
- Generalises the fixed 256x22 tag RAM in four ways: configurable width and depth, lane write enables, selectable read latency and read-during-write mode.
- Adds a built-in clear sequencer that sweeps every entry to CLEAR_VALUE after reset or on request, so cache invalidation needs no external walker.
- Sits under the I/D-cache tag and valid arrays.

Parameters:
- DATA_WIDTH, 22, bits per word.
- DEPTH, 256, number of words; power of two, at least 2.
- ADDR_WIDTH, $clog2(DEPTH), address bits; derived, never overridden.
- LANE_WIDTH, DATA_WIDTH, bits per write lane.
- LANES, ceil(DATA_WIDTH/LANE_WIDTH), derived. The last lane may be narrower than LANE_WIDTH.
- READ_LATENCY, 1, 1 or 2 cycles from request to rdata. A value of 2 adds an output register.
- WRITE_MODE, 0, read-during-write data: 0 = read-first (old data), 1 = write-first (merged new data).
- CLEAR_VALUE, '0, word written by the clear sequencer.
- CLEAR_ON_RESET, 1, when 1, reset enters the CLEAR state.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  access request
- we  in  1  write qualifier; valid only with en
- wbe  in  LANES  lane write enables; valid only with en&we
- addr  in  ADDR_WIDTH  word address
- wdata  in  DATA_WIDTH  write data
- rdata  out  DATA_WIDTH  read data
- rvalid  out  1  one-cycle pulse when rdata is new
- clear_req  in  1  start a full clear
- ready  out  1  accepts user accesses

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: rdata=0, rvalid=0, pipeline stages cleared, clear counter=0. ready=0 if CLEAR_ON_RESET, else ready=1. Array contents are not reset.
- FSM states: CLEAR and READY.
  - Reset goes to CLEAR if CLEAR_ON_RESET, else to READY.
  - In CLEAR, cnt runs from 0 to DEPTH-1, writing CLEAR_VALUE to all lanes at address cnt, one word per cycle. After the cnt==DEPTH-1 write, the FSM enters READY; ready rises on the next cycle. The sweep takes exactly DEPTH cycles.
  - READY with clear_req=1 goes to CLEAR next cycle with cnt=0. ready drops in that same cycle.
  - clear_req during CLEAR is ignored; no restart.
  - rst during CLEAR restarts the sweep from 0.
- Access acceptance: a user access is accepted only when ready=1 and en=1.
  - en while ready=0 is dropped silently: no array change, no rvalid.
  - en in the same cycle as clear_req is still accepted and completes normally.
- Read (en, !we):
  - READ_LATENCY=1: rdata and rvalid are updated at the first edge after the request.
  - READ_LATENCY=2: rdata and rvalid are updated at the second edge.
  - Back-to-back reads are fully pipelined, one per cycle.
- Write (en, we): each lane i with wbe[i]=1 takes wdata lane i; all other lanes keep their contents. Writes also produce rvalid after READ_LATENCY:
  - WRITE_MODE=0: rdata = pre-write word.
  - WRITE_MODE=1: rdata = post-write merged word.
- wbe=0 with we=1: no change; still returns rdata and rvalid per mode.
- rdata holds its last value when rvalid=0; it never reverts to 0 except on rst.
- Read of an address written on the previous cycle returns the new data (array semantics; no bypass needed beyond this).
- In-flight reads in the latency-2 pipeline complete even if CLEAR starts.
- Clear writes never generate rvalid.

Decomposition:
- ram_pkg holds:
  - clr_state_e {CLR_CLEAR, CLR_READY}
  - wr_mode_e {WR_READ_FIRST, WR_WRITE_FIRST}
  - a function lane_mask(wbe) that expands wbe to a DATA_WIDTH bit mask.
- Sub-module spram_core: a behavioural array with per-bit write mask and one-cycle registered read honouring WRITE_MODE. It swaps for a foundry macro.
- spram_clr owns the FSM, the address/data mux between the clear sweep and the user port, and the optional second output stage.

Test Plan:
- Defaults, rst for 1 cycle -> ready=0 for exactly 256 cycles, then 1; reads of addresses 0, 127 and 255 return 22'h0 with rvalid one cycle after each request.
- Write 22'h3ABCDE to addr 5, then read 5 next cycle -> rdata=22'h3ABCDE with rvalid at +1; READ_LATENCY=2 build -> +2.
- LANE_WIDTH=8 (LANES=3): write 22'h3FFFFF, then wbe=3'b010 with wdata=22'h000000 -> read gives 22'h3F00FF.
- WRITE_MODE=0: addr 9 holds 22'h000011; write 22'h000022 -> rdata=22'h000011. WRITE_MODE=1 build -> rdata=22'h000022. Both pulse rvalid.
- When ready, assert clear_req with a concurrent write to addr 3 -> write accepted, ready low for 256 cycles; en pulses during the sweep give no rvalid; a second clear_req mid-sweep does not extend it; afterwards addr 3 reads 0.
- rst asserted at sweep cycle 100 -> ready stays low for 256 further cycles; rdata=0 and rvalid=0 right after reset.
